// File: rtl/csr_exec_pkg.sv
// Shared types and constants for the CSR execute stage.
package csr_exec_pkg;

    // CSR operation encoding as carried on req_op_type.
    typedef enum logic [1:0] {
        CSR_RW = 2'd0,
        CSR_RS = 2'd1,
        CSR_RC = 2'd2,
        CSR_RO = 2'd3
    } csr_op_e;

    // Request sequencing: accept, read the file, modify/write, present commit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } csr_state_e;

    // Per-lane thread index; served locally instead of from the CSR file.
    localparam logic [11:0] CSR_THREAD_ID = 12'hCC0;

endpackage

// File: rtl/csr_exec_alu.sv
// Combinational read-modify-write datapath: computes the new CSR value and
// whether the file actually needs to be written.
module csr_exec_alu
    import csr_exec_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [31:0] old_i,
    input  logic [31:0] src_i,
    output logic [31:0] new_o,
    output logic        wr_en_o
);

    logic src_nz;

    assign src_nz = |src_i;

    // RW always writes; set/clear with an all-zero mask and read-only leave the CSR untouched.
    always_comb begin
        new_o   = old_i;
        wr_en_o = 1'b0;
        case (csr_op_e'(op_i))
            CSR_RW: begin
                new_o   = src_i;
                wr_en_o = 1'b1;
            end
            CSR_RS: begin
                new_o   = old_i | src_i;
                wr_en_o = src_nz;
            end
            CSR_RC: begin
                new_o   = old_i & ~src_i;
                wr_en_o = src_nz;
            end
            default: begin
                new_o   = old_i;
                wr_en_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_exec_unit.sv
// CSR execute stage: accepts one CSR request at a time, performs a single
// read-modify-write of the core CSR file and commits the old value to every
// active lane.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; a producer holds valid and its payload stable until that
// edge, and ready may depend on state but never on valid in the same cycle.
module csr_exec_unit
    import csr_exec_pkg::*;
#(
    parameter int NUM_THREADS   = 4,
    parameter int NW_BITS       = 2,
    parameter int UUID_BITS     = 44,
    parameter int XLEN          = 32,
    parameter int NR_BITS       = 5,
    parameter int NRI_BITS      = 5,
    parameter int CSR_ADDR_BITS = 12,
    parameter int TID_BITS      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       req_valid,
    input  logic [UUID_BITS-1:0]       req_uuid,
    input  logic [NW_BITS-1:0]         req_wid,
    input  logic [NUM_THREADS-1:0]     req_tmask,
    input  logic [XLEN-1:0]            req_PC,
    input  logic [1:0]                 req_op_type,
    input  logic [CSR_ADDR_BITS-1:0]   req_addr,
    input  logic [TID_BITS-1:0]        req_tid,
    input  logic [NUM_THREADS*32-1:0]  req_rs1_data,
    input  logic                       req_use_imm,
    input  logic [NRI_BITS-1:0]        req_imm,
    input  logic [NR_BITS-1:0]         req_rd,
    input  logic                       req_wb,
    output logic                       req_ready,

    output logic                       csr_rd_en,
    output logic [CSR_ADDR_BITS-1:0]   csr_rd_addr,
    input  logic [31:0]                csr_rd_data,
    output logic                       csr_wr_en,
    output logic [CSR_ADDR_BITS-1:0]   csr_wr_addr,
    output logic [31:0]                csr_wr_data,

    output logic                       cmt_valid,
    output logic [UUID_BITS-1:0]       cmt_uuid,
    output logic [NW_BITS-1:0]         cmt_wid,
    output logic [NUM_THREADS-1:0]     cmt_tmask,
    output logic [XLEN-1:0]            cmt_PC,
    output logic [NR_BITS-1:0]         cmt_rd,
    output logic                       cmt_wb,
    output logic [NUM_THREADS*32-1:0]  cmt_data,
    input  logic                       cmt_ready,

    output logic [1:0]                 dbg_state
);

    localparam logic [CSR_ADDR_BITS-1:0] TID_ADDR = CSR_ADDR_BITS'(CSR_THREAD_ID);

    csr_state_e                 state_q;

    // Request fields captured on accept.
    logic [UUID_BITS-1:0]       uuid_q;
    logic [NW_BITS-1:0]         wid_q;
    logic [NUM_THREADS-1:0]     tmask_q;
    logic [XLEN-1:0]            pc_q;
    logic [1:0]                 op_q;
    logic [CSR_ADDR_BITS-1:0]   addr_q;
    logic [TID_BITS-1:0]        tid_q;
    logic [NUM_THREADS*32-1:0]  rs1_q;
    logic                       use_imm_q;
    logic [NRI_BITS-1:0]        imm_q;
    logic [NR_BITS-1:0]         rd_q;
    logic                       wb_q;

    // Commit bundle, registered at the end of EXEC.
    logic                       cmt_valid_q;
    logic [UUID_BITS-1:0]       cmt_uuid_q;
    logic [NW_BITS-1:0]         cmt_wid_q;
    logic [NUM_THREADS-1:0]     cmt_tmask_q;
    logic [XLEN-1:0]            cmt_pc_q;
    logic [NR_BITS-1:0]         cmt_rd_q;
    logic                       cmt_wb_q;
    logic [NUM_THREADS*32-1:0]  cmt_data_q;
    logic [NUM_THREADS*32-1:0]  cmt_data_d;

    logic [31:0]                rs1_sel;
    logic [31:0]                src;
    logic [31:0]                alu_new;
    logic                       alu_wr;
    logic                       is_tid_csr;

    // Pick the operand lane chosen by tid out of the latched rs1 vector.
    always_comb begin
        rs1_sel = 32'd0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (tid_q == TID_BITS'(i)) begin
                rs1_sel = rs1_q[i*32 +: 32];
            end
        end
    end

    assign src        = use_imm_q ? {{(32-NRI_BITS){1'b0}}, imm_q} : rs1_sel;
    assign is_tid_csr = (addr_q == TID_ADDR);

    csr_exec_alu u_alu (
        .op_i    (op_q),
        .old_i   (csr_rd_data),
        .src_i   (src),
        .new_o   (alu_new),
        .wr_en_o (alu_wr)
    );

    // Per-lane result: the old CSR value (or the lane index for the thread-id
    // CSR) for active lanes, zero for inactive ones.
    always_comb begin
        cmt_data_d = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (tmask_q[i]) begin
                cmt_data_d[i*32 +: 32] = is_tid_csr ? 32'(i) : csr_rd_data;
            end
        end
    end

    // Sequencer: accept in IDLE, one read cycle, one modify/write cycle, then
    // hold the commit until the writeback side takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            uuid_q      <= '0;
            wid_q       <= '0;
            tmask_q     <= '0;
            pc_q        <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            tid_q       <= '0;
            rs1_q       <= '0;
            use_imm_q   <= 1'b0;
            imm_q       <= '0;
            rd_q        <= '0;
            wb_q        <= 1'b0;
            cmt_valid_q <= 1'b0;
            cmt_uuid_q  <= '0;
            cmt_wid_q   <= '0;
            cmt_tmask_q <= '0;
            cmt_pc_q    <= '0;
            cmt_rd_q    <= '0;
            cmt_wb_q    <= 1'b0;
            cmt_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        uuid_q    <= req_uuid;
                        wid_q     <= req_wid;
                        tmask_q   <= req_tmask;
                        pc_q      <= req_PC;
                        op_q      <= req_op_type;
                        addr_q    <= req_addr;
                        tid_q     <= req_tid;
                        rs1_q     <= req_rs1_data;
                        use_imm_q <= req_use_imm;
                        imm_q     <= req_imm;
                        rd_q      <= req_rd;
                        wb_q      <= req_wb;
                        state_q   <= READ;
                    end
                end
                READ: begin
                    state_q <= EXEC;
                end
                EXEC: begin
                    cmt_valid_q <= 1'b1;
                    cmt_uuid_q  <= uuid_q;
                    cmt_wid_q   <= wid_q;
                    cmt_tmask_q <= tmask_q;
                    cmt_pc_q    <= pc_q;
                    cmt_rd_q    <= rd_q;
                    cmt_wb_q    <= wb_q;
                    cmt_data_q  <= cmt_data_d;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (cmt_ready) begin
                        cmt_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by reset so an abort suppresses any read or write in flight.
    assign req_ready   = (state_q == IDLE) && !reset;
    assign csr_rd_en   = (state_q == READ) && !reset;
    assign csr_rd_addr = addr_q;
    assign csr_wr_en   = (state_q == EXEC) && alu_wr && !reset;
    assign csr_wr_addr = addr_q;
    assign csr_wr_data = alu_new;

    assign cmt_valid = cmt_valid_q;
    assign cmt_uuid  = cmt_uuid_q;
    assign cmt_wid   = cmt_wid_q;
    assign cmt_tmask = cmt_tmask_q;
    assign cmt_PC    = cmt_pc_q;
    assign cmt_rd    = cmt_rd_q;
    assign cmt_wb    = cmt_wb_q;
    assign cmt_data  = cmt_data_q;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed testbench for csr_exec_unit with a behavioural CSR file and a
// commit/write scoreboard.
module tb_csr_exec_unit;

    logic         clk;
    logic         reset;

    logic         req_valid;
    logic [43:0]  req_uuid;
    logic [1:0]   req_wid;
    logic [3:0]   req_tmask;
    logic [31:0]  req_PC;
    logic [1:0]   req_op_type;
    logic [11:0]  req_addr;
    logic [1:0]   req_tid;
    logic [127:0] req_rs1_data;
    logic         req_use_imm;
    logic [4:0]   req_imm;
    logic [4:0]   req_rd;
    logic         req_wb;
    logic         req_ready;

    logic         csr_rd_en;
    logic [11:0]  csr_rd_addr;
    logic [31:0]  csr_rd_data;
    logic         csr_wr_en;
    logic [11:0]  csr_wr_addr;
    logic [31:0]  csr_wr_data;

    logic         cmt_valid;
    logic [43:0]  cmt_uuid;
    logic [1:0]   cmt_wid;
    logic [3:0]   cmt_tmask;
    logic [31:0]  cmt_PC;
    logic [4:0]   cmt_rd;
    logic         cmt_wb;
    logic [127:0] cmt_data;
    logic         cmt_ready;
    logic [1:0]   dbg_state;

    csr_exec_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_uuid     (req_uuid),
        .req_wid      (req_wid),
        .req_tmask    (req_tmask),
        .req_PC       (req_PC),
        .req_op_type  (req_op_type),
        .req_addr     (req_addr),
        .req_tid      (req_tid),
        .req_rs1_data (req_rs1_data),
        .req_use_imm  (req_use_imm),
        .req_imm      (req_imm),
        .req_rd       (req_rd),
        .req_wb       (req_wb),
        .req_ready    (req_ready),
        .csr_rd_en    (csr_rd_en),
        .csr_rd_addr  (csr_rd_addr),
        .csr_rd_data  (csr_rd_data),
        .csr_wr_en    (csr_wr_en),
        .csr_wr_addr  (csr_wr_addr),
        .csr_wr_data  (csr_wr_data),
        .cmt_valid    (cmt_valid),
        .cmt_uuid     (cmt_uuid),
        .cmt_wid      (cmt_wid),
        .cmt_tmask    (cmt_tmask),
        .cmt_PC       (cmt_PC),
        .cmt_rd       (cmt_rd),
        .cmt_wb       (cmt_wb),
        .cmt_data     (cmt_data),
        .cmt_ready    (cmt_ready),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural CSR file ----------------
    logic [31:0] csr_mem [0:4095];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) csr_mem[pl_addr] <= pl_data;
        if (csr_wr_en && csr_wr_addr != 12'hCC0) csr_mem[csr_wr_addr] <= csr_wr_data;
        if (csr_rd_en) csr_rd_data <= csr_mem[csr_rd_addr];
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [43:0]  uuid;
        logic [1:0]   wid;
        logic [3:0]   tmask;
        logic [31:0]  pc;
        logic [4:0]   rd;
        logic         wb;
        logic [127:0] data;
    } cmt_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    cmt_t exp_q[$];
    wr_t  wr_q[$];

    int n_vec = 0;
    int n_err = 0;
    logic [43:0] next_uuid = 44'h100;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops the expected write and commit whenever the DUT presents one.
    initial begin
        cmt_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (csr_wr_en) begin
                    if (wr_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_write: got addr %h data %h expected no write", csr_wr_addr, csr_wr_data);
                    end else begin
                        w = wr_q.pop_front();
                        check("wr_addr", 128'(csr_wr_addr), 128'(w.addr));
                        check("wr_data", 128'(csr_wr_data), 128'(w.data));
                    end
                end
                if (cmt_valid && cmt_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_commit: got uuid %h expected none", cmt_uuid);
                    end else begin
                        e = exp_q.pop_front();
                        check("cmt_uuid",  128'(cmt_uuid),  128'(e.uuid));
                        check("cmt_wid",   128'(cmt_wid),   128'(e.wid));
                        check("cmt_tmask", 128'(cmt_tmask), 128'(e.tmask));
                        check("cmt_PC",    128'(cmt_PC),    128'(e.pc));
                        check("cmt_rd",    128'(cmt_rd),    128'(e.rd));
                        check("cmt_wb",    128'(cmt_wb),    128'(e.wb));
                        check("cmt_data",  cmt_data,        e.data);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [11:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Issue one request, check the accept-to-commit timing, optionally wait
    // for the commit handshake to finish.
    task automatic send(input logic [1:0] op, input logic [11:0] addr, input logic [1:0] tid,
                        input logic [127:0] rs1, input logic use_imm, input logic [4:0] imm,
                        input logic [3:0] tmask, input logic wb,
                        input logic exp_wr, input logic [31:0] exp_wr_data,
                        input logic [127:0] exp_data, input logic wait_done);
        cmt_t e;
        wr_t  w;
        int   budget;
        @(negedge clk);
        req_uuid     = next_uuid;
        req_wid      = next_uuid[1:0];
        req_PC       = 32'h1000 + 32'(next_uuid[7:0]) * 4;
        req_rd       = next_uuid[4:0];
        req_wb       = wb;
        req_tmask    = tmask;
        req_op_type  = op;
        req_addr     = addr;
        req_tid      = tid;
        req_rs1_data = rs1;
        req_use_imm  = use_imm;
        req_imm      = imm;
        req_valid    = 1'b1;
        e.uuid  = req_uuid;
        e.wid   = req_wid;
        e.tmask = tmask;
        e.pc    = req_PC;
        e.rd    = req_rd;
        e.wb    = wb;
        e.data  = exp_data;
        exp_q.push_back(e);
        if (exp_wr) begin
            w.addr = addr;
            w.data = exp_wr_data;
            wr_q.push_back(w);
        end
        next_uuid = next_uuid + 1;
        budget = 0;
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("req_ready_idle", 128'(req_ready), 128'(1'b1));
        @(posedge clk);          // accept edge N
        #1;
        req_valid = 1'b0;
        @(negedge clk);          // cycle N+1
        check("rd_en_n1", 128'(csr_rd_en), 128'(1'b1));
        check("rd_addr", 128'(csr_rd_addr), 128'(addr));
        check("req_ready_busy", 128'(req_ready), 128'(1'b0));
        @(negedge clk);          // cycle N+2
        check("rd_en_n2", 128'(csr_rd_en), 128'(1'b0));
        check("cmt_valid_n2", 128'(cmt_valid), 128'(1'b0));
        @(negedge clk);          // cycle N+3
        check("cmt_valid_n3", 128'(cmt_valid), 128'(1'b1));
        if (wait_done) begin
            budget = 0;
            while (cmt_valid && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            check("cmt_done", 128'(cmt_valid), 128'(1'b0));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_uuid     = '0;
        req_wid      = '0;
        req_tmask    = '0;
        req_PC       = '0;
        req_op_type  = '0;
        req_addr     = '0;
        req_tid      = '0;
        req_rs1_data = '0;
        req_use_imm  = 1'b0;
        req_imm      = '0;
        req_rd       = '0;
        req_wb       = 1'b0;
        cmt_ready    = 1'b1;
        pl_en        = 1'b0;
        pl_addr      = '0;
        pl_data      = '0;
        csr_rd_data  = '0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 128'(req_ready), 128'(1'b0));
        check("rst_cmt_valid", 128'(cmt_valid), 128'(1'b0));
        check("rst_rd_en",     128'(csr_rd_en), 128'(1'b0));
        check("rst_wr_en",     128'(csr_wr_en), 128'(1'b0));
        check("rst_cmt_data",  cmt_data, 128'd0);
        check("rst_cmt_uuid",  128'(cmt_uuid), 128'd0);
        check("rst_state",     128'(dbg_state), 128'd0);
        reset = 1'b0;

        preload(12'h300, 32'hAAAA);
        preload(12'h301, 32'h5);
        preload(12'h302, 32'hFF);
        preload(12'h303, 32'h1);
        preload(12'hCC0, 32'hDEAD);

        // RW from lane 2: write 0x1234, every lane sees the old 0xAAAA.
        send(2'd0, 12'h300, 2'd2, {32'h0, 32'h1234, 32'h9999, 32'h7777}, 1'b0, 5'd0,
             4'b1111, 1'b1, 1'b1, 32'h1234, {4{32'hAAAA}}, 1'b1);
        // RS with zero immediate: no write.
        send(2'd1, 12'h301, 2'd0, {4{32'hFFFF_FFFF}}, 1'b1, 5'd0,
             4'b1111, 1'b1, 1'b0, 32'h0, {4{32'h5}}, 1'b1);
        // RS with immediate 3: 5|3 = 7.
        send(2'd1, 12'h301, 2'd0, 128'd0, 1'b1, 5'd3,
             4'b1111, 1'b1, 1'b1, 32'h7, {4{32'h5}}, 1'b1);
        // RC 0xF0 from lane 0 on 0xFF with lanes 0 and 2 active.
        send(2'd2, 12'h302, 2'd0, {32'h0F0F, 32'h3, 32'h1, 32'hF0}, 1'b0, 5'd0,
             4'b0101, 1'b1, 1'b1, 32'h0F, {32'h0, 32'hFF, 32'h0, 32'hFF}, 1'b1);
        // Read-only thread-id CSR: lane indices, no write even with a nonzero operand.
        send(2'd3, 12'hCC0, 2'd0, {4{32'hFFFF}}, 1'b0, 5'd0,
             4'b1111, 1'b1, 1'b0, 32'h0, {32'd3, 32'd2, 32'd1, 32'd0}, 1'b1);
        // Read-only on a normal CSR with one active lane sees the earlier RW value.
        send(2'd3, 12'h300, 2'd1, {4{32'h1}}, 1'b1, 5'd7,
             4'b1000, 1'b1, 1'b0, 32'h0, {32'h1234, 32'h0, 32'h0, 32'h0}, 1'b1);
        // RW to thread-id CSR with wb=0: write forwarded unchanged, commit still issued.
        send(2'd0, 12'hCC0, 2'd3, {32'h55, 32'h0, 32'h0, 32'h0}, 1'b0, 5'd0,
             4'b1010, 1'b0, 1'b1, 32'h55, {32'd3, 32'd0, 32'd1, 32'd0}, 1'b1);

        // Commit back-pressure: hold cmt_ready low for 5 cycles.
        cmt_ready = 1'b0;
        send(2'd1, 12'h303, 2'd1, {32'h0, 32'h0, 32'h100, 32'h0}, 1'b0, 5'd0,
             4'b0011, 1'b1, 1'b1, 32'h101, {32'h0, 32'h0, 32'h1, 32'h1}, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 128'(cmt_valid), 128'(1'b1));
            check("stall_data",  cmt_data, {32'h0, 32'h0, 32'h1, 32'h1});
            check("stall_uuid",  128'(cmt_uuid), 128'(next_uuid - 1));
            check("stall_req_ready", 128'(req_ready), 128'(1'b0));
        end
        @(posedge clk);
        #1;
        cmt_ready = 1'b1;
        @(negedge clk);          // monitor takes the commit here
        @(negedge clk);
        check("stall_released", 128'(cmt_valid), 128'(1'b0));

        // Reset while in READ aborts the request.
        @(negedge clk);
        req_uuid     = 44'hBAD;
        req_op_type  = 2'd0;
        req_addr     = 12'h302;
        req_tid      = 2'd0;
        req_rs1_data = {4{32'hBEEF}};
        req_use_imm  = 1'b0;
        req_tmask    = 4'b1111;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("abort_in_read", 128'(dbg_state), 128'd1);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_rd_en", 128'(csr_rd_en), 128'(1'b0));
        check("abort_req_ready", 128'(req_ready), 128'(1'b0));
        check("abort_state", 128'(dbg_state), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_commit", 128'(cmt_valid), 128'(1'b0));
        check("abort_idle_ready", 128'(req_ready), 128'(1'b1));

        // Normal request after the abort: RC imm 1 on 7 gives 6; 0x302 kept 0x0F.
        send(2'd2, 12'h301, 2'd0, 128'd0, 1'b1, 5'd1,
             4'b1111, 1'b1, 1'b1, 32'h6, {4{32'h7}}, 1'b1);
        send(2'd3, 12'h302, 2'd0, 128'd0, 1'b0, 5'd0,
             4'b0001, 1'b1, 1'b0, 32'h0, {32'h0, 32'h0, 32'h0, 32'h0F}, 1'b1);

        repeat (5) @(negedge clk);
        check("exp_q_drained", 128'(exp_q.size()), 128'd0);
        check("wr_q_drained",  128'(wr_q.size()),  128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/csr_exec_unit.md
Name: csr_exec_unit

Overview:
- Execute stage that consumes the CSR request bundle (valid/ready) from the dispatch side and produces a writeback/commit bundle.
- Per request it does one read-modify-write of the core CSR file and returns the old CSR value to the destination register of every active lane.
- One request in flight at a time.
- Sits between the CSR request interface and the commit/writeback arbiter.

Parameters:
- NUM_THREADS, 4, lanes per warp
- NW_BITS, 2, warp-id width
- UUID_BITS, 44, instruction uuid width
- XLEN, 32, PC width
- NR_BITS, 5, register index width
- NRI_BITS, 5, CSR immediate width
- CSR_ADDR_BITS, 12, CSR address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_uuid  in  UUID_BITS  instruction uuid
- req_wid  in  NW_BITS  warp id
- req_tmask  in  NUM_THREADS  active-lane mask
- req_PC  in  XLEN  instruction PC
- req_op_type  in  2  operation: 0 RW, 1 RS, 2 RC, 3 read-only
- req_addr  in  CSR_ADDR_BITS  CSR address
- req_tid  in  log2(NUM_THREADS)  lane that supplies the rs1 operand
- req_rs1_data  in  NUM_THREADS*32  per-lane rs1 values
- req_use_imm  in  1  select the immediate as operand
- req_imm  in  NRI_BITS  zimm operand
- req_rd  in  NR_BITS  destination register
- req_wb  in  1  writeback enable
- req_ready  out  1  request accepted when valid&ready
- csr_rd_en  out  1  CSR file read strobe
- csr_rd_addr  out  CSR_ADDR_BITS  read address
- csr_rd_data  in  32  read data, valid the cycle after csr_rd_en
- csr_wr_en  out  1  CSR file write strobe
- csr_wr_addr  out  CSR_ADDR_BITS  write address
- csr_wr_data  out  32  write data
- cmt_valid  out  1  commit valid
- cmt_uuid, cmt_wid, cmt_tmask, cmt_PC, cmt_rd, cmt_wb  out  as req_*  forwarded request fields
- cmt_data  out  NUM_THREADS*32  per-lane result
- cmt_ready  in  1  commit consumer ready

Behaviour:
- Clock is clk; reset is asynchronous and active-high.
- Reset state: state=IDLE, req_ready=0 while reset is asserted, cmt_valid=0, csr_rd_en=0, csr_wr_en=0, all latched fields 0, cmt_data=0.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch all req_* fields and go to READ.
  - READ: req_ready=0. Assert csr_rd_en for exactly 1 cycle with csr_rd_addr=latched addr. Go to EXEC.
  - EXEC: old=csr_rd_data. src = use_imm ? zero-extend(imm) : rs1_data[tid].
    - new = RW: src; RS: old|src; RC: old&~src.
    - Write suppression: RS/RC with src==0, and op 3, produce no write. RW always writes.
    - When a write occurs: csr_wr_en=1 (combinational, this cycle only), csr_wr_addr=addr, csr_wr_data=new.
    - Register cmt_data and the forwarded fields; set cmt_valid=1 at the clock edge; go to RESP.
  - RESP: hold cmt_* stable while cmt_valid=1 and cmt_ready=0. On cmt_ready, clear cmt_valid and go to IDLE.
- Result data:
  - Lane i with tmask[i]=1 receives old, except addr==CSR_THREAD_ID (0xCC0), where lane i receives i.
  - Lanes with tmask[i]=0 receive 0.
- Thread-id CSR: reads are served locally and still issue csr_rd_en. Writes to it are forwarded to the CSR file unchanged; the file ignores them.
- Latency: accept at edge N → csr_rd_en during cycle N+1 → write during N+2 → cmt_valid from N+3. Minimum 4 cycles per request; no accept outside IDLE.
- cmt_wb=0 still produces a commit; the CSR write side effect still happens.
- Reset mid-operation aborts the request: no further read or write, no commit, return to IDLE.
- A pending write in EXEC is dropped when reset asserts in the same cycle.

Decomposition:
- csr_exec_pkg:
  - op enum {CSR_RW, CSR_RS, CSR_RC, CSR_RO}
  - state enum {IDLE, READ, EXEC, RESP}
  - CSR_THREAD_ID=12'hCC0
- Sub-module csr_exec_alu: combinational (op, old, src) → (new, wr_en). Instantiated once.

Test Plan:
- RW, rs1_data[tid=2]=0x1234, CSR holds 0xAAAA, tmask=4'b1111 → wr 0x1234, cmt_data all lanes 0xAAAA, cmt_valid at N+3.
- RS with use_imm=1, imm=0, CSR=0x5 → no csr_wr_en; cmt_data=0x5; RS imm=0x3 → wr 0x7.
- RC, src=0xF0, CSR=0xFF, tmask=4'b0101 → wr 0x0F; lanes 0 and 2 get 0xFF, lanes 1 and 3 get 0.
- Read of 0xCC0 with tmask=4'b1111 → cmt_data={3,2,1,0}.
- cmt_ready low 5 cycles → cmt_* stable, req_ready=0; single commit after ready rises.
- Reset asserted in READ → no csr_wr_en, no cmt_valid; the next request completes normally.
